// File: rtl/fa_4bit_hier_pkg.sv
// Shared constants for the hierarchical ripple-carry adder.
// Holds the default operand width used by the top level.
package fa_4bit_hier_pkg;

    localparam int FA_WIDTH = 4;

endpackage

// File: rtl/fa_4bit_hier_full_adder.sv
// One-bit full-adder cell.
// The ripple-carry adder chains these cells, least-significant bit first.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/fa_4bit_hier.sv
// Ripple-carry adder built from WIDTH full-adder cells.
// It has a combinational sum/carry and a one-cycle registered copy for synchronous consumers.
module fa_4bit_hier
    import fa_4bit_hier_pkg::*;
#(
    parameter int WIDTH = FA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic [WIDTH-1:0] s_q,
    output logic             co_q
);

    // c[i] is the carry into cell i; c[WIDTH] leaves the top cell.
    logic [WIDTH:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign co = c[WIDTH];

    // Reset clears only the registered copy; s/co always follow the inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q  <= '0;
            co_q <= 1'b0;
        end else begin
            s_q  <= s;
            co_q <= co;
        end
    end

endmodule

// File: tb/tb_fa_4bit_hier.sv
// Directed and sweep bench for fa_4bit_hier.
// It checks the combinational sum, the registered copy and the reset behaviour.
module tb_fa_4bit_hier;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       ci;
    logic [3:0] s;
    logic       co;
    logic [3:0] s_q;
    logic       co_q;

    int checks   = 0;
    int failures = 0;

    fa_4bit_hier #(.WIDTH(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .ci   (ci),
        .s    (s),
        .co   (co),
        .s_q  (s_q),
        .co_q (co_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] va, input logic [3:0] vb, input logic vci);
        a  = va;
        b  = vb;
        ci = vci;
    endtask

    initial begin
        logic [31:0] r;
        logic [4:0]  exp_sum;

        rst = 1'b1;
        drive(4'd0, 4'd0, 1'b0);
        @(posedge clk);
        #1;
        check_val("reset_s_q", {5'd0, s_q}, 9'd0);
        check_val("reset_co_q", {8'd0, co_q}, 9'd0);
        rst = 1'b0;

        // Directed combinational vectors
        drive(4'd3, 4'd5, 1'b0);
        #1;
        check_val("comb_3_5_0", {4'd0, co, s}, 9'd8);
        drive(4'd15, 4'd15, 1'b1);
        #1;
        check_val("comb_max", {4'd0, co, s}, 9'd31);
        drive(4'd0, 4'd0, 1'b0);
        #1;
        check_val("comb_zero", {4'd0, co, s}, 9'd0);
        drive(4'd10, 4'd5, 1'b1);
        #1;
        check_val("comb_propagate", {4'd0, co, s}, 9'd16);

        // Random vectors, same bit mapping as the sweep
        for (int k = 0; k < 12; k++) begin
            r = $urandom;
            drive(r[8:5], r[4:1], r[0]);
            exp_sum = {1'b0, r[8:5]} + {1'b0, r[4:1]} + {4'd0, r[0]};
            #1;
            check_val("comb_rand", {4'd0, co, s}, {4'd0, exp_sum});
        end

        // Exhaustive sweep
        for (int v = 0; v < 512; v++) begin
            r = v;
            drive(r[8:5], r[4:1], r[0]);
            exp_sum = {1'b0, r[8:5]} + {1'b0, r[4:1]} + {4'd0, r[0]};
            #1;
            check_val("comb_sweep", {4'd0, co, s}, {4'd0, exp_sum});
        end

        // Reset held for two edges
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(4'd9, 4'd9, 1'b1);
        #1;
        check_val("rst_comb", {4'd0, co, s}, 9'd19);
        @(posedge clk);
        #1;
        check_val("rst_edge1", {4'd0, co_q, s_q}, 9'd0);
        @(posedge clk);
        #1;
        check_val("rst_edge2", {4'd0, co_q, s_q}, 9'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_val("rst_release", {4'd0, co_q, s_q}, 9'd19);

        // Mid-cycle input changes
        drive(4'd1, 4'd1, 1'b0);
        #1;
        check_val("mid_comb_a", {4'd0, co, s}, 9'd2);
        check_val("mid_hold_a", {4'd0, co_q, s_q}, 9'd19);
        #1;
        drive(4'd7, 4'd8, 1'b0);
        #1;
        check_val("mid_comb_b", {4'd0, co, s}, 9'd15);
        check_val("mid_hold_b", {4'd0, co_q, s_q}, 9'd19);
        @(posedge clk);
        #1;
        check_val("mid_capture", {4'd0, co_q, s_q}, 9'd15);

        // Registered path with carry-out
        drive(4'd15, 4'd15, 1'b1);
        @(posedge clk);
        #1;
        check_val("reg_max", {4'd0, co_q, s_q}, 9'd31);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
